data_mem_responder: RTL

//  Responder end of the processor's load/store memory interface: accepts one word

---
 rtl/data_mem_if.sv | 25 ++
 rtl/data_mem_responder.sv | 119 +++++++++++
 2 files changed

// File: rtl/data_mem_if.sv
// Load/store memory bundle between the datapath (master) and the data memory responder (slave).
// Handshake: a request transfers on a rising edge where req_valid && req_ready; the master
// holds req_* stable while req_valid is high; resp_valid is a one-cycle strobe with no back-pressure.
interface data_mem_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-wide data memory responder: one request at a time, WAIT_STATES cycles before the access,
// single-cycle response. Define DMEM_MISALIGN_TRAP_EN to reject addresses with req_addr[1:0] != 0.
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst,
    data_mem_if.slave  bus,
    output logic       busy,
    output logic [1:0] state_dbg
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic               wr_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        mem [DEPTH];

    logic [IDX_W-1:0]   req_idx;
    logic [MEM_AW-1:0]  mem_idx;
    logic               oob;
    logic               err_chk;
    logic               accept;
    logic               access;

    assign req_idx = bus.req_addr[ADDR_W-1:2];
    assign mem_idx = MEM_AW'(idx_q);
    assign oob     = (32'(req_idx) >= 32'(DEPTH));
    assign accept  = bus.req_valid && bus.req_ready;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign err_chk = oob || (bus.req_addr[1:0] != 2'b00);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^bus.req_addr[1:0];
    assign err_chk = oob;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ready is masked by rst so nothing is accepted on a reset edge
    always_comb begin
        bus.req_ready = 1'b0;
        busy          = 1'b0;
        access        = 1'b0;
        case (state)
            IDLE:    bus.req_ready = !rst;
            ACCESS: begin
                busy   = 1'b1;
                access = (cnt == 4'd0);
            end
            RESP:    busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= bus.req_write;
            idx_q   <= req_idx;
            wdata_q <= bus.req_wdata;
            err_q   <= err_chk;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= 4'd0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            if (accept) cnt <= 4'(WAIT_STATES);
            if (state == ACCESS) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= err_q;
                    bus.resp_rdata <= (err_q || wr_q) ? 32'd0 : mem[mem_idx];
                end
            end
        end
    end

    // A reset landing on the access edge cancels the store
    always_ff @(posedge clk) begin
        if (!rst && access && wr_q && !err_q) mem[mem_idx] <= wdata_q;
    end
endmodule
